// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared types and constants for the three-digit seven-segment
// scan driver.
//   state_t     FSM states for load / convert / commit sequencing
//   SEG_BLANK   segment pattern of a blanked digit (before polarity)
//   IDX_W       width of the scanned digit index (0..2)
//   hex_to_seg  nibble -> {g,f,e,d,c,b,a}, active-high
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam int         IDX_W     = 2;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load handshake between the result source and the
// display driver.
//   load      single-cycle capture strobe (source -> driver)
//   value     8-bit unsigned number to show
//   dec_mode  0 = two hex digits, 1 = up to three decimal digits
//   busy      driver is converting/committing; load is dropped while high
interface seg7_scan_driver_if;
   logic       load;
   logic [7:0] value;
   logic       dec_mode;
   logic       busy;

   modport master (output load, output value, output dec_mode, input busy);
   modport slave  (input load, input value, input dec_mode, output busy);
endinterface

// File: rtl/seg7_scan_driver_bin2bcd_serial.sv
// bin2bcd_serial: 8-bit binary to 12-bit BCD by serial double-dabble.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       capture bin and begin; ignored while a conversion runs
//   bin         binary input, sampled on start
//   done        high during the eighth (final) shift cycle
//   bcd         {hundreds, tens, ones}; valid from the cycle after done
// One input bit is consumed per cycle, MSB first, exactly 8 cycles.
module bin2bcd_serial (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        done,
   output logic [11:0] bcd
);

   logic [7:0] shreg;
   logic [2:0] cnt;
   logic       run;

   // Add-3 on any BCD digit >= 5, then shift the next binary bit in.
   // Hundreds never exceeds 2, so the bit shifted out of [11] is always 0.
   function automatic logic [11:0] dd_step(input logic [11:0] b, input logic in);
      logic [11:0] t;
      t = b;
      for (int i = 0; i < 3; i++) begin
         if (t[i*4 +: 4] >= 4'd5)
            t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
      end
      return {t[10:0], in};
   endfunction

   assign done = run && (cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
         cnt   <= '0;
         run   <= 1'b0;
         bcd   <= '0;
      end else if (run) begin
         bcd   <= dd_step(bcd, shreg[7]);
         shreg <= {shreg[6:0], 1'b0};
         cnt   <= cnt + 3'd1;
         if (cnt == 3'd7)
            run <= 1'b0;
      end else if (start) begin
         shreg <= bin;
         cnt   <= '0;
         run   <= 1'b1;
         bcd   <= '0;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: captures an 8-bit result, converts it to hex or
// unsigned-decimal digits and scans a three-digit multiplexed seven-segment
// display with leading-zero blanking.
//   REFRESH_DIV   cycles each digit is held (>= 2)
//   COMMON_ANODE  1 inverts seg and dig (active-low pins)
//   clk, reset    rising-edge clock, synchronous active-high reset
//   host          load/value/dec_mode in, busy out
//   seg           {g,f,e,d,c,b,a}, registered
//   dig           one-hot digit enable, registered: [0]=ones, [1]=tens, [2]=hundreds
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter logic [23:0] REFRESH_DIV  = 24'd10_000,
   parameter bit          COMMON_ANODE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   seg7_scan_driver_if.slave host,
   output logic [6:0]        seg,
   output logic [2:0]        dig
);

   localparam logic [23:0] SCAN_LAST = REFRESH_DIV - 24'd1;
   localparam logic [6:0]  SEG_POL   = COMMON_ANODE ? 7'h7F : 7'h00;
   localparam logic [2:0]  DIG_POL   = COMMON_ANODE ? 3'h7  : 3'h0;

   // ---------------------------------------------------------------- FSM
   state_t state, state_nxt;
   logic   accept, start, commit, conv_done;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (host.load) state_nxt = host.dec_mode ? ST_CONVERT : ST_COMMIT;
         ST_CONVERT: if (conv_done) state_nxt = ST_COMMIT;
         ST_COMMIT:  state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      host.busy = (state != ST_IDLE);
      accept    = (state == ST_IDLE) && host.load;
      start     = accept && host.dec_mode;
      commit    = (state == ST_COMMIT);
   end

   // ------------------------------------------------------ capture/convert
   logic [7:0]  val_q;
   logic        dec_q;
   logic [11:0] bcd;

   always_ff @(posedge clk) begin
      if (reset) begin
         val_q <= '0;
         dec_q <= 1'b1;
      end else if (accept) begin
         val_q <= host.value;
         dec_q <= host.dec_mode;
      end
   end

   // The converter samples value directly on start, in step with val_q.
   bin2bcd_serial u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (host.value),
      .done  (conv_done),
      .bcd   (bcd)
   );

   // ---------------------------------------------------- display registers
   // Index [2] = hundreds, [1] = tens / high nibble, [0] = ones / low nibble.
   logic [2:0][3:0] disp_q, new_d, disp_sel;
   logic [2:0]      blank_q, new_blank, blank_sel;

   always_comb begin
      if (dec_q) begin
         new_d        = bcd;
         new_blank[2] = (bcd[11:8] == 4'd0);
         new_blank[1] = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
         new_blank[0] = 1'b0;
      end else begin
         new_d     = {4'h0, val_q[7:4], val_q[3:0]};
         new_blank = 3'b100;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q  <= '0;
         blank_q <= 3'b110;
      end else if (commit) begin
         disp_q  <= new_d;
         blank_q <= new_blank;
      end
   end

   // Output registers are fed from the post-commit view so the new digits
   // appear on seg the cycle after COMMIT, all positions together.
   assign disp_sel  = commit ? new_d     : disp_q;
   assign blank_sel = commit ? new_blank : blank_q;

   // ------------------------------------------------------------- scanning
   logic [23:0]      scan_cnt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             wrap;

   assign wrap = (scan_cnt == SCAN_LAST);

   always_comb begin
      idx_nxt = idx;
      if (wrap)
         idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else begin
         scan_cnt <= wrap ? 24'd0 : scan_cnt + 24'd1;
         idx      <= idx_nxt;
      end
   end

   // ------------------------------------------------------------- outputs
   logic [3:0] cur_d;
   logic       cur_blank;
   logic [6:0] seg_raw;
   logic [2:0] dig_raw;

   always_comb begin
      case (idx_nxt)
         2'd1: begin cur_d = disp_sel[1]; cur_blank = blank_sel[1]; dig_raw = 3'b010; end
         2'd2: begin cur_d = disp_sel[2]; cur_blank = blank_sel[2]; dig_raw = 3'b100; end
         default: begin cur_d = disp_sel[0]; cur_blank = blank_sel[0]; dig_raw = 3'b001; end
      endcase
      seg_raw = cur_blank ? SEG_BLANK : hex_to_seg(cur_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= hex_to_seg(4'h0) ^ SEG_POL;
         dig <= 3'b001 ^ DIG_POL;
      end else begin
         seg <= seg_raw ^ SEG_POL;
         dig <= dig_raw ^ DIG_POL;
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Display-side counterpart of the keypad encoder. Captures an 8-bit result (the ALU output) on a load strobe, converts it to hex or unsigned-decimal digits, and drives a three-digit, time-multiplexed seven-segment display with leading-zero blanking. Sits between the ALU result bus and the dedicated output pins.

## Interface
- `REFRESH_DIV`, default 24'd10_000: clock cycles each digit is held; minimum 2.
- `COMMON_ANODE`, default 0: when 1, `seg` and `dig` are inverted (active-low).

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `value` and `dec_mode`.
- `value`  in  8  unsigned number to display.
- `dec_mode`  in  1  0 = two hex digits; 1 = up to three decimal digits.
- `busy`  out  1  conversion in progress; `load` is ignored while high.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, registered; active-high when `COMMON_ANODE`=0.
- `dig`  out  3  one-hot digit enable, registered: `dig[0]` = ones, `dig[1]` = tens/low-high nibble, `dig[2]` = hundreds.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE + `load`: latch `value` and mode.
  - Hex mode: go to COMMIT. Digits are {blank, value[7:4], value[3:0]}.
  - Decimal mode: go to CONVERT.
- CONVERT: serial double-dabble, one input bit per cycle, MSB first, for exactly 8 cycles. Produces a 12-bit BCD result (hundreds 0–2). Then go to COMMIT.
- COMMIT: write all three display digit registers and the blank flags atomically, then return to IDLE.
- Display registers change only in COMMIT. No partial updates are ever visible.
- Blanking, decimal mode:
  - Hundreds digit is blank if 0.
  - Tens digit is blank if hundreds and tens are both 0.
  - Ones digit is never blank.
- Blanking, hex mode: both nibbles are always shown; the hundreds position is always blank.
- A blank digit drives `seg` = 7'h00 (pre-inversion). `dig` still asserts for that position.
- Segment codes, 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Scan counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→0.
- `seg` and `dig` are registered from the current index and committed digits, and change in the same cycle.
- Reset values:
  - Committed digits {0,0,0}, decimal mode, so the display shows "0".
  - Index 0, scan counter 0, FSM in IDLE.
  - `busy`=0, `dig`=3'b001, `seg`=7'h3F (all inverted if `COMMON_ANODE`=1).
- Reset during CONVERT/COMMIT aborts the conversion; the display returns to reset values.
- `load` while `busy` (including the COMMIT cycle) is dropped. There is no queue.

## Timing
- `load` sampled at cycle N.
- Hex mode:
  - `busy`=1 during N+1 (COMMIT).
  - New digits are visible on `seg` from N+2 for whichever position is being scanned.
- Decimal mode:
  - CONVERT during N+1..N+8; COMMIT at N+9.
  - `busy`=1 during N+1..N+9; new digits visible from N+10.
- `load` is accepted again at N+2 (hex) or N+10 (decimal).
- Digit change: `dig` advances in the cycle after the scan counter equals REFRESH_DIV-1. Full refresh period = 3·REFRESH_DIV cycles.
- The scan runs continuously, independent of the FSM and `busy`.

## Structure
- Package `seg7_pkg` holds:
  - FSM state enum;
  - `SEG_BLANK` constant;
  - the 16-entry hex-to-segment table / function `hex_to_seg`;
  - the digit-index width constant.
- Sub-module `bin2bcd_serial`: 8-bit to 12-bit BCD double-dabble.
  - Ports: `start`, `done`, `bin`, `bcd`, plus `clk` and `reset`.
  - Exactly 8 shift cycles per conversion.
- Top contains the FSM, display registers, scan counter and output registers.

## Test plan
- Reset, then check `dig`=001, `seg`=3F, `busy`=0. Let the scan run a full refresh period: `dig`=010 and `dig`=100 both show `seg`=00.
- Hex load: `value`=8'hA7, `dec_mode`=0. Check `busy` is high 1 cycle. Over one full scan: `dig`=001 → 07, 010 → 77, 100 → 00.
- Decimal load: `value`=255, `dec_mode`=1. Check `busy` is high 9 cycles. Then 001 → 6D, 010 → 6D, 100 → 5B.
- Blanking:
  - `value`=7, decimal: ones → 07; tens and hundreds → 00.
  - `value`=100, decimal: 3F, 3F, 06 (interior zeros are not blanked).
- Load during conversion and reset mid-conversion:
  - Load 200 decimal, then pulse `load`=5 at N+4: the second load is dropped and the display shows 200.
  - Load again, then assert `reset` at N+5: `busy`→0 and the display shows "0" next cycle.
- Parameters, with `REFRESH_DIV`=4 and `COMMON_ANODE`=1:
  - `dig` steps every 4 cycles and wraps 100→001.
  - After reset, `dig`=3'b110 and `seg`=7'h40.
